// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - constants and arbiter state type shared across the router
package router_pkg;

  localparam int NUM_PORTS = 16;
  localparam int PORT_ID_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANTED = 2'd1,
    DRAIN   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_priority_picker.sv
// rtl/rr_priority_picker.sv - round-robin winner search starting at ptr
module rr_priority_picker
  import router_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PORT_ID_W-1:0] ptr,
  output logic [PORT_ID_W-1:0] winner,
  output logic                 found
);

  logic [2*NUM_PORTS-1:0] w_double;
  logic [NUM_PORTS-1:0]   w_rot;
  logic [PORT_ID_W-1:0]   w_offset;

  // Rotating the doubled vector puts port ptr at bit 0, so the lowest set bit is the winner.
  assign w_double = {req, req} >> ptr;
  assign w_rot    = w_double[NUM_PORTS-1:0];

  always_comb begin
    w_offset = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_offset = PORT_ID_W'(i);
      end
    end
  end

  assign winner = ptr + w_offset;
  assign found  = |req;

endmodule

// File: rtl/router_output_arbiter.sv
// rtl/router_output_arbiter.sv - per-output round-robin arbiter with frame lock and hold watchdog
module router_output_arbiter #(
  parameter int NUM_PORTS = 16,
  parameter int TIMEOUT   = 0
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [NUM_PORTS-1:0]             request16_in,
  output logic [NUM_PORTS-1:0]             grant16_out,
  output logic                             busy_out,
  output logic [router_pkg::PORT_ID_W-1:0] owner_out,
  output logic                             timeout_out
);
  import router_pkg::*;

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  arb_state_t           r_state;
  logic [PORT_ID_W-1:0] r_ptr;
  logic [CNT_W-1:0]     r_hold_cnt;
  logic [PORT_ID_W-1:0] w_winner;
  logic                 w_found;
  logic                 w_owner_req;
  logic [NUM_PORTS-1:0] w_one;

  assign w_one       = {{(NUM_PORTS-1){1'b0}}, 1'b1};
  assign w_owner_req = request16_in[owner_out];

  rr_priority_picker u_picker (
    .req    (request16_in),
    .ptr    (r_ptr),
    .winner (w_winner),
    .found  (w_found)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_hold_cnt  <= '0;
      grant16_out <= '0;
      busy_out    <= 1'b0;
      owner_out   <= '0;
      timeout_out <= 1'b0;
    end else begin
      timeout_out <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_found) begin
            grant16_out <= w_one << w_winner;
            owner_out   <= w_winner;
            busy_out    <= 1'b1;
            r_ptr       <= w_winner + PORT_ID_W'(1);
            r_hold_cnt  <= '0;
            r_state     <= GRANTED;
          end
        end
        GRANTED: begin
          // A normal end of frame takes precedence over a watchdog expiry on the same edge.
          if (!w_owner_req) begin
            grant16_out <= '0;
            busy_out    <= 1'b0;
            r_state     <= IDLE;
          end else if ((TIMEOUT != 0) && (r_hold_cnt == CNT_W'(TIMEOUT - 1))) begin
            grant16_out <= '0;
            busy_out    <= 1'b0;
            timeout_out <= 1'b1;
            r_state     <= DRAIN;
          end else if (r_hold_cnt != {CNT_W{1'b1}}) begin
            r_hold_cnt <= r_hold_cnt + CNT_W'(1);
          end
        end
        DRAIN: begin
          if (!w_owner_req) begin
            r_state <= IDLE;
          end
        end
        default: begin
          grant16_out <= '0;
          busy_out    <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_router_output_arbiter.sv
// tb/tb_router_output_arbiter.sv - self-checking bench for router_output_arbiter (TIMEOUT 0 and 8)
module tb_router_output_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] req = '0;

  logic [15:0] g0, g8;
  logic        b0, b8, t0, t8;
  logic [3:0]  o0, o8;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  router_output_arbiter #(.NUM_PORTS(16), .TIMEOUT(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .request16_in(req),
    .grant16_out(g0), .busy_out(b0), .owner_out(o0), .timeout_out(t0)
  );

  router_output_arbiter #(.NUM_PORTS(16), .TIMEOUT(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .request16_in(req),
    .grant16_out(g8), .busy_out(b8), .owner_out(o8), .timeout_out(t8)
  );

  typedef struct {
    logic [15:0] req;
    logic [15:0] grant;
    logic        busy;
    logic [3:0]  owner;
  } vec_t;

  vec_t tbl[16];

  // Reference model: 0 = idle, 1 = granted, 2 = draining after a watchdog release
  int m_mode[2];
  int m_own[2];
  int m_ptr[2];
  int m_cnt[2];
  int m_to[2];
  int m_lim[2] = '{0, 8};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic [15:0] r);
    req = r;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    req = '0;
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic check_both(input string name, input logic [15:0] eg, input logic eb,
                            input logic [3:0] eo, input logic et);
    check({name, " grant0"}, 32'(g0), 32'(eg));
    check({name, " busy0"},  32'(b0), 32'(eb));
    check({name, " owner0"}, 32'(o0), 32'(eo));
    check({name, " tout0"},  32'(t0), 32'(et));
    check({name, " grant8"}, 32'(g8), 32'(eg));
    check({name, " busy8"},  32'(b8), 32'(eb));
    check({name, " owner8"}, 32'(o8), 32'(eo));
    check({name, " tout8"},  32'(t8), 32'(et));
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = 0; m_own[k] = 0; m_ptr[k] = 0; m_cnt[k] = 0; m_to[k] = 0;
    end
  endtask

  task automatic model_step(input int k, input logic [15:0] r);
    m_to[k] = 0;
    if (m_mode[k] == 1) begin
      if (!r[m_own[k]]) m_mode[k] = 0;
      else if (m_lim[k] != 0 && m_cnt[k] == m_lim[k] - 1) begin
        m_mode[k] = 2;
        m_to[k] = 1;
      end else m_cnt[k]++;
    end else if (m_mode[k] == 2) begin
      if (!r[m_own[k]]) m_mode[k] = 0;
    end else begin
      for (int n = 0; n < 16; n++) begin
        int p;
        p = (m_ptr[k] + n) % 16;
        if (r[p]) begin
          m_own[k]  = p;
          m_ptr[k]  = (p + 1) % 16;
          m_mode[k] = 1;
          m_cnt[k]  = 0;
          break;
        end
      end
    end
  endtask

  task automatic model_compare(input int k, input int cyc);
    logic [15:0] eg;
    logic [15:0] one;
    logic [15:0] ag;
    logic        ab, at;
    logic [3:0]  ao;
    one = 16'h0001;
    eg  = (m_mode[k] == 1) ? (one << m_own[k]) : 16'h0000;
    ag  = (k == 0) ? g0 : g8;
    ab  = (k == 0) ? b0 : b8;
    ao  = (k == 0) ? o0 : o8;
    at  = (k == 0) ? t0 : t8;
    check($sformatf("rand c%0d d%0d grant", cyc, k), 32'(ag), 32'(eg));
    check($sformatf("rand c%0d d%0d busy", cyc, k), 32'(ab), 32'(m_mode[k] == 1));
    check($sformatf("rand c%0d d%0d owner", cyc, k), 32'(ao), 32'(m_own[k]));
    check($sformatf("rand c%0d d%0d tout", cyc, k), 32'(at), 32'(m_to[k]));
  endtask

  initial begin
    int ghigh;
    int tcount;
    int tcyc;
    int regrant;
    logic [15:0] r;

    tbl[0]  = '{16'h0000, 16'h0000, 1'b0, 4'd0};
    tbl[1]  = '{16'h8001, 16'h0001, 1'b1, 4'd0};
    tbl[2]  = '{16'h8001, 16'h0001, 1'b1, 4'd0};
    tbl[3]  = '{16'h8000, 16'h0000, 1'b0, 4'd0};
    tbl[4]  = '{16'h8000, 16'h8000, 1'b1, 4'd15};
    tbl[5]  = '{16'h8001, 16'h8000, 1'b1, 4'd15};
    tbl[6]  = '{16'h0000, 16'h0000, 1'b0, 4'd15};
    tbl[7]  = '{16'h8001, 16'h0001, 1'b1, 4'd0};
    tbl[8]  = '{16'h0000, 16'h0000, 1'b0, 4'd0};
    tbl[9]  = '{16'h0020, 16'h0020, 1'b1, 4'd5};
    tbl[10] = '{16'hFFFF, 16'h0020, 1'b1, 4'd5};
    tbl[11] = '{16'hFFDF, 16'h0000, 1'b0, 4'd5};
    tbl[12] = '{16'hFFDF, 16'h0040, 1'b1, 4'd6};
    tbl[13] = '{16'h0000, 16'h0000, 1'b0, 4'd6};
    tbl[14] = '{16'h0008, 16'h0008, 1'b1, 4'd3};
    tbl[15] = '{16'h0000, 16'h0000, 1'b0, 4'd3};

    @(negedge clk);
    do_reset();
    check_both("reset", 16'h0000, 1'b0, 4'd0, 1'b0);

    for (int i = 0; i < 16; i++) begin
      step(tbl[i].req);
      check_both($sformatf("row%0d", i), tbl[i].grant, tbl[i].busy, tbl[i].owner, 1'b0);
    end

    // Watchdog: port 2 holds 20 cycles with port 9 pending
    do_reset();
    ghigh = 0; tcount = 0; tcyc = -1; regrant = 0;
    for (int c = 1; c <= 20; c++) begin
      step(16'h0204);
      if (g8 != 16'h0000) begin
        ghigh++;
        if (tcount != 0) regrant++;
        check($sformatf("wd c%0d grant8", c), 32'(g8), 32'h0004);
      end
      if (t8) begin
        tcount++;
        tcyc = c;
        check("wd pulse grant8 low", 32'(g8), 32'h0);
      end
    end
    check("wd grant cycles", 32'(ghigh), 32'd8);
    check("wd pulses", 32'(tcount), 32'd1);
    check("wd pulse cycle", 32'(tcyc), 32'd9);
    check("wd regrant", 32'(regrant), 32'd0);
    check("wd busy8 in drain", 32'(b8), 32'd0);
    check("wd grant0 held", 32'(g0), 32'h0004);
    step(16'h0200);
    check("wd exit grant8", 32'(g8), 32'h0000);
    check("wd exit grant0", 32'(g0), 32'h0000);
    step(16'h0200);
    check("wd p9 grant8", 32'(g8), 32'h0200);
    check("wd p9 owner8", 32'(o8), 32'd9);
    check("wd p9 grant0", 32'(g0), 32'h0200);
    step(16'h0000);

    // Asynchronous reset while granted, then ptr must be back at 0
    step(16'h0001);
    step(16'h0001);
    check("mid grant8 before", 32'(g8), 32'h0001);
    #2;
    reset_n = 1'b0;
    #1;
    check_both("async reset", 16'h0000, 1'b0, 4'd0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    step(16'h0003);
    check_both("post reset", 16'h0001, 1'b1, 4'd0, 1'b0);

    // Random frames against the reference model
    do_reset();
    model_reset();
    r = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 16; b++) begin
        if ($urandom_range(0, 9) == 0) r[b] = ~r[b];
      end
      step(r);
      for (int k = 0; k < 2; k++) begin
        model_step(k, r);
        model_compare(k, c);
      end
      check($sformatf("rand c%0d onehot0", c), 32'($onehot0(g0) && (b0 == |g0)), 32'd1);
      check($sformatf("rand c%0d onehot8", c), 32'($onehot0(g8) && (b8 == |g8)), 32'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
